serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
- Serial pattern transmitter: shifts a 5-bit sequence (default 10010) out MSB-first on a single-bit line `w`, one bit per bit-rate tick.
- Drives the serial input of the lab's sequence detectors for self-checking loopback on the board.
- Supports a built-in or externally supplied pattern, repeated frames, optional inter-frame gap, and abort.

Parameters:
- WIDTH, 5: pattern length in bits.
- PATTERN, 5'b10010: built-in pattern, MSB transmitted first.
- CNT_W, 4: width of repetition count and frame counter.
- GAP, 0: number of tick periods of idle (w=0, w_valid=0) inserted between repeated frames.

Ports:
- clk, input, 1: system clock, all logic on posedge.
- rest, input, 1: asynchronous active-low reset.
- tick, input, 1: bit-rate enable, one clk wide (from clock divider); bit boundaries occur only on clk edges where tick=1.
- start, input, 1: one-clk request pulse; honoured only in IDLE.
- use_ext, input, 1: 1 = transmit ext_pattern, 0 = PATTERN; sampled at load.
- ext_pattern, input, WIDTH: external pattern; sampled at load.
- reps, input, CNT_W: frames per run; 0 treated as 1; sampled at load.
- abort, input, 1: synchronous cancel.
- w, output, 1: serial data.
- w_valid, output, 1: high while w carries a pattern bit.
- busy, output, 1: high from start acceptance until run end.
- done, output, 1: one-clk pulse at normal run completion.
- frame_cnt, output, CNT_W: frames completed in current/last run.

Behaviour:
- Reset (rest=0, async):
  - State = IDLE.
  - w=0, w_valid=0, busy=0, done=0, frame_cnt=0.
  - Pending flag cleared, shift register cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE, start=1 (clk edge):
  - pend<=1, busy<=1.
  - Move to WAIT; latch nothing yet.
- WAIT, first clk edge with tick=1 (load):
  - Latch pattern (ext or PATTERN), reps_eff = (reps==0)?1:reps, frame_cnt<=0.
  - w<=pattern[WIDTH-1], w_valid<=1, bit_idx<=WIDTH-1.
  - Move to SEND.
- SEND, tick=1:
  - bit_idx>0: shift left, w<=next bit, bit_idx--.
  - bit_idx==0 (frame ends): frame_cnt<=frame_cnt+1, then:
    - frame_cnt+1 == reps_eff: w<=0, w_valid<=0, busy<=0, done<=1, state IDLE.
    - else if GAP>0: w<=0, w_valid<=0, gap_cnt<=GAP-1, state GAP.
    - else (GAP=0): reload latched pattern, w<=MSB, bit_idx<=WIDTH-1, stay in SEND (back-to-back frames, no idle bit).
- GAP, tick=1:
  - gap_cnt>0: gap_cnt--.
  - gap_cnt==0: reload, w<=MSB, w_valid<=1, state SEND.
- Bit timing: every transmitted bit lasts exactly one tick period (tick edge to next tick edge). The first bit begins on the load tick, never before.
- tick=0: state and outputs hold.
- done: high for exactly one clk, on the edge of the final bit's ending tick.
- start while busy=1: ignored, no queueing.
- abort=1 (any non-IDLE state):
  - Next edge: IDLE, w=0, w_valid=0, busy=0, pend cleared.
  - done NOT pulsed; frame_cnt holds completed frame count.
  - abort has priority over tick and start on the same edge.
- Simultaneous start and abort in IDLE: abort wins, request dropped.
- use_ext, ext_pattern and reps changes after load: no effect until the next run.
- frame_cnt saturates at 2^CNT_W-1 (unreachable with reps ≤ that value; guard anyway).
- Reset mid-run: immediate IDLE per reset values; no done pulse.

Test Plan:
- Defaults; tick every 4 clks; start, use_ext=0, reps=1 → w = 1,0,0,1,0, each held 4 clks starting at first tick after start; w_valid high for 20 clks; done one pulse at the 6th tick; frame_cnt=1; busy falls with done.
- reps=3, GAP=0 → w = 100101001010010 continuously, no gap; frame_cnt steps 1,2,3; single done pulse. Loopback into a Moore 10010 detector on the same tick sees the expected overlapping detections.
- GAP=2, reps=2, use_ext=1, ext_pattern=5'b11011 → 1,1,0,1,1, two tick periods of w=0/w_valid=0, then 1,1,0,1,1, done; frame_cnt=2.
- reps=0 → exactly one frame sent, done pulsed, frame_cnt=1.
- abort asserted during bit 3 of frame 2 (reps=3) → next clk w=0, w_valid=0, busy=0, no done, frame_cnt=1. A start pulse during busy before the abort is ignored.
- rest pulled low mid-frame, asynchronous to clk → outputs reset immediately. After release, a new start transmits a full frame correctly from the MSB.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - serial pattern transmitter, MSB-first, tick-paced, framed repeats
module serial_pattern_tx #(
  parameter int                WIDTH   = 5,
  parameter logic [WIDTH-1:0]  PATTERN = 5'b10010,
  parameter int                CNT_W   = 4,
  parameter int                GAP     = 0
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             tick,
  input  logic             start,
  input  logic             use_ext,
  input  logic [WIDTH-1:0] ext_pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic             abort,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [CNT_W-1:0] fc_q, fc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             w_q, w_d;
  logic             wv_q, wv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pend_q, pend_d;

  logic [WIDTH-1:0] load_pat;
  logic [CNT_W-1:0] fc_nxt;

  assign load_pat = use_ext ? ext_pattern : PATTERN;
  // Saturating frame count; only reachable if reps_eff could exceed the counter range.
  assign fc_nxt   = (fc_q == '1) ? fc_q : fc_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    reps_d  = reps_q;
    fc_d    = fc_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    w_d     = w_q;
    wv_d    = wv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pend_d  = pend_q;
    if (abort) begin
      state_d = S_IDLE;
      w_d     = 1'b0;
      wv_d    = 1'b0;
      busy_d  = 1'b0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          pend_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
        S_WAIT: if (tick) begin
          pat_d   = load_pat;
          sh_d    = load_pat;
          reps_d  = (reps == '0) ? CNT_W'(1) : reps;
          fc_d    = '0;
          w_d     = load_pat[WIDTH-1];
          wv_d    = 1'b1;
          idx_d   = IDX_W'(WIDTH - 1);
          pend_d  = 1'b0;
          state_d = S_SEND;
        end
        S_SEND: if (tick) begin
          if (idx_q != '0) begin
            sh_d  = sh_q << 1;
            w_d   = sh_q[WIDTH-2];
            idx_d = idx_q - 1'b1;
          end else begin
            fc_d = fc_nxt;
            if (fc_nxt == reps_q) begin
              w_d     = 1'b0;
              wv_d    = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else if (GAP > 0) begin
              w_d     = 1'b0;
              wv_d    = 1'b0;
              gap_d   = GAP_W'(GAP - 1);
              state_d = S_GAP;
            end else begin
              sh_d  = pat_q;
              w_d   = pat_q[WIDTH-1];
              idx_d = IDX_W'(WIDTH - 1);
            end
          end
        end
        S_GAP: if (tick) begin
          if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
          end else begin
            sh_d    = pat_q;
            w_d     = pat_q[WIDTH-1];
            wv_d    = 1'b1;
            idx_d   = IDX_W'(WIDTH - 1);
            state_d = S_SEND;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      reps_q  <= '0;
      fc_q    <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      w_q     <= 1'b0;
      wv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      reps_q  <= reps_d;
      fc_q    <= fc_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      w_q     <= w_d;
      wv_q    <= wv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign w         = w_q;
  assign w_valid   = wv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = fc_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - directed checks of serial_pattern_tx with GAP=0 and GAP=2 instances
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rest, tick, start, use_ext, abort;
  logic [4:0] ext_pattern;
  logic [3:0] reps;
  logic       w0, wv0, busy0, done0;
  logic       w2, wv2, busy2, done2;
  logic [3:0] fc0, fc2;
  int         total = 0;
  int         passed = 0;
  int         det = 0;
  logic [3:0] hist = '0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.GAP(0)) dut0 (
    .clk(clk), .rest(rest), .tick(tick), .start(start), .use_ext(use_ext),
    .ext_pattern(ext_pattern), .reps(reps), .abort(abort),
    .w(w0), .w_valid(wv0), .busy(busy0), .done(done0), .frame_cnt(fc0));

  serial_pattern_tx #(.GAP(2)) dut2 (
    .clk(clk), .rest(rest), .tick(tick), .start(start), .use_ext(use_ext),
    .ext_pattern(ext_pattern), .reps(reps), .abort(abort),
    .w(w2), .w_valid(wv2), .busy(busy2), .done(done2), .frame_cnt(fc2));

  // Reference 10010 detector fed by the GAP=0 line, advancing on each tick.
  always @(posedge clk) begin
    if (tick && wv0) begin
      hist <= {hist[2:0], w0};
      if ({hist, w0} == 5'b10010) det <= det + 1;
    end
  end

  function automatic logic g_w(input int s);       return s ? w2 : w0;       endfunction
  function automatic logic g_wv(input int s);      return s ? wv2 : wv0;     endfunction
  function automatic logic g_busy(input int s);    return s ? busy2 : busy0; endfunction
  function automatic logic g_done(input int s);    return s ? done2 : done0; endfunction
  function automatic logic [3:0] g_fc(input int s); return s ? fc2 : fc0;    endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_clk();
    @(posedge clk); #1;
  endtask

  task automatic tick_clk();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic start_run(input int s);
    abort = 1'b1; idle_clk(); abort = 1'b0;
    start = 1'b1; idle_clk(); start = 1'b0;
    chk("busy_on_start", g_busy(s), 1);
    chk("wv_before_load", g_wv(s), 0);
    idle_clk();
    chk("w_before_load", g_w(s), 0);
  endtask

  task automatic periods(input int s, input logic [31:0] bits, input logic [31:0] valid,
                         input int nper, input int start_at, input bit mangle);
    int vcnt = 0;
    for (int i = 0; i < nper; i++) begin
      tick_clk();
      chk($sformatf("w_p%0d", i), g_w(s), bits[nper-1-i]);
      chk($sformatf("wv_p%0d", i), g_wv(s), valid[nper-1-i]);
      chk($sformatf("busy_p%0d", i), g_busy(s), 1);
      chk($sformatf("fc_p%0d", i), g_fc(s), vcnt / 5);
      if (valid[nper-1-i]) vcnt++;
      if (mangle && i == 0) begin
        ext_pattern = ~ext_pattern; reps = 4'd1; use_ext = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        if (k == 0 && i == start_at) start = 1'b1;
        idle_clk();
        start = 1'b0;
        chk($sformatf("w_hold_p%0d", i), g_w(s), bits[nper-1-i]);
        chk("done_low", g_done(s), 0);
      end
    end
  endtask

  task automatic finish_run(input int s, input int frames);
    tick_clk();
    chk("done_pulse", g_done(s), 1);
    chk("busy_end", g_busy(s), 0);
    chk("w_end", g_w(s), 0);
    chk("wv_end", g_wv(s), 0);
    chk("fc_end", g_fc(s), frames);
    idle_clk();
    chk("done_one_clk", g_done(s), 0);
  endtask

  initial begin
    int det_base;
    rest = 1'b0; tick = 1'b0; start = 1'b0; use_ext = 1'b0; abort = 1'b0;
    ext_pattern = 5'b0; reps = 4'd1;
    #1;
    chk("rst_w", w0, 0); chk("rst_wv", wv0, 0); chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0); chk("rst_fc", fc0, 0); chk("rst_busy2", busy2, 0);
    repeat (2) idle_clk();
    rest = 1'b1;
    idle_clk();

    // Single frame of the built-in pattern
    start_run(0);
    periods(0, 32'b10010, 32'b11111, 5, -1, 0);
    finish_run(0, 1);

    // Three back-to-back frames, loopback detections
    reps = 4'd3; det_base = det;
    start_run(0);
    periods(0, 32'b100101001010010, 32'h7fff, 15, -1, 0);
    finish_run(0, 3);
    chk("loopback_detections", det - det_base, 3);

    // External pattern, two frames with a two-period gap; inputs change after load
    reps = 4'd2; use_ext = 1'b1; ext_pattern = 5'b11011;
    start_run(1);
    periods(1, 32'b110110011011, 32'b111110011111, 12, -1, 1);
    finish_run(1, 2);

    // reps=0 means one frame
    reps = 4'd0; use_ext = 1'b0;
    start_run(0);
    periods(0, 32'b10010, 32'b11111, 5, -1, 0);
    finish_run(0, 1);

    // Abort in frame 2, with an ignored start during busy
    reps = 4'd3;
    start_run(0);
    periods(0, 32'b10010100, 32'hff, 8, 2, 0);
    abort = 1'b1; idle_clk(); abort = 1'b0;
    chk("abort_w", w0, 0); chk("abort_wv", wv0, 0); chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0); chk("abort_fc", fc0, 1);
    tick_clk(); idle_clk();
    chk("abort_stays_idle_wv", wv0, 0); chk("abort_no_done", done0, 0);
    chk("abort_stays_idle_busy", busy0, 0);

    // Asynchronous reset in frame 2, then a clean frame
    reps = 4'd2;
    start_run(0);
    periods(0, 32'b1001010, 32'h7f, 7, -1, 0);
    @(posedge clk); #3;
    rest = 1'b0; #1;
    chk("arst_w", w0, 0); chk("arst_wv", wv0, 0); chk("arst_busy", busy0, 0);
    chk("arst_fc", fc0, 0); chk("arst_done", done0, 0);
    idle_clk(); #2;
    rest = 1'b1;
    reps = 4'd1;
    idle_clk();
    start_run(0);
    periods(0, 32'b10010, 32'b11111, 5, -1, 0);
    finish_run(0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
